// File: rtl/gshare_predictor_pkg.sv
// Shared predictor types: direction state, counter storage type, reset value.
// GSHARE_HISTORY_EN selects gshare hashing; bimodal indexing when undefined.
package gshare_predictor_pkg;

  typedef enum logic [1:0] {
    ST_SNT,
    ST_WNT,
    ST_WT,
    ST_ST
  } pred_state_e;

  localparam int CTR_W_MAX = 4;

  typedef logic [CTR_W_MAX-1:0] ctr_t;

  localparam ctr_t CTR_WEAK_TAKEN_2 = ctr_t'(ST_WT);

  function automatic ctr_t weak_taken(input int unsigned w);
    ctr_t v;
    v = '0;
    v[w-1] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/gshare_predictor_sat_counter.sv
// One saturating up/down counter of the pattern history table.
// Exposes only its MSB, which is the taken/not-taken prediction.
module sat_counter
  import gshare_predictor_pkg::*;
#(
  parameter int W = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic inc_i,
  input  logic dec_i,
  output logic taken_o
);

  localparam ctr_t RST_C = weak_taken(W);
  localparam logic [W-1:0] RST_V = RST_C[W-1:0];

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i) begin
      if (inc_i && (cnt_q != '1)) begin
        cnt_d = cnt_q + W'(1);
      end else if (dec_i && (cnt_q != '0)) begin
        cnt_d = cnt_q - W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= RST_V;
    else     cnt_q <= cnt_d;
  end

  assign taken_o = cnt_q[W-1];

endmodule

// File: rtl/gshare_predictor.sv
// Gshare direction predictor: PC xor global history indexes a counter table.
// GSHARE_HISTORY_EN enables the history register; otherwise bimodal.
module gshare_predictor
  import gshare_predictor_pkg::*;
#(
  parameter int PHT_DEPTH = 64,
  parameter int CTR_WIDTH = 2,
  parameter int HIST_LEN  = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pred_valid_i,
  input  logic [31:0]         pred_pc_i,
  output logic                pred_taken_o,
  output logic [HIST_LEN-1:0] pred_ghr_o,
  input  logic                upd_valid_i,
  input  logic [31:0]         upd_pc_i,
  input  logic [HIST_LEN-1:0] upd_ghr_i,
  input  logic                upd_taken_i,
  input  logic                upd_mispredict_i
);

  localparam int IW = $clog2(PHT_DEPTH);

  logic [IW-1:0]        pred_idx;
  logic [IW-1:0]        upd_idx;
  logic [PHT_DEPTH-1:0] msb;

  logic unused_pc;
  assign unused_pc = ^{pred_pc_i[31:IW+2], pred_pc_i[1:0],
                       upd_pc_i[31:IW+2], upd_pc_i[1:0]};

`ifdef GSHARE_HISTORY_EN
  logic [HIST_LEN-1:0] ghr_q, ghr_d;

  assign pred_idx = pred_pc_i[IW+1:2] ^ IW'(ghr_q);
  assign upd_idx  = upd_pc_i[IW+1:2] ^ IW'(upd_ghr_i);

  // A mispredict repair wins over the speculative fetch shift.
  always_comb begin
    ghr_d = ghr_q;
    if (upd_valid_i && upd_mispredict_i) begin
      ghr_d = HIST_LEN'({upd_ghr_i, upd_taken_i});
    end else if (pred_valid_i) begin
      ghr_d = HIST_LEN'({ghr_q, pred_taken_o});
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ghr_q <= '0;
    else     ghr_q <= ghr_d;
  end

  assign pred_ghr_o = ghr_q;
`else
  logic unused_hist;

  assign pred_idx    = pred_pc_i[IW+1:2];
  assign upd_idx     = upd_pc_i[IW+1:2];
  assign pred_ghr_o  = '0;
  assign unused_hist = ^{upd_ghr_i, upd_mispredict_i, pred_valid_i};
`endif

  for (genvar i = 0; i < PHT_DEPTH; i++) begin : g_pht
    sat_counter #(
      .W(CTR_WIDTH)
    ) u_ctr (
      .clk     (clk),
      .rst     (rst),
      .en_i    (upd_valid_i && (upd_idx == IW'(i))),
      .inc_i   (upd_taken_i),
      .dec_i   (!upd_taken_i),
      .taken_o (msb[i])
    );
  end

  assign pred_taken_o = msb[pred_idx];

endmodule

// File: tb/tb_gshare_predictor.sv
// Scoreboard bench for gshare_predictor against an array-based model.
// Follows GSHARE_HISTORY_EN so either build mode is checked.
module tb_gshare_predictor;

  localparam int D    = 64;
  localparam int W    = 2;
  localparam int HL   = 6;
  localparam int CMAX = (1 << W) - 1;
  localparam int WT   = 1 << (W - 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          pred_valid = 1'b0;
  logic [31:0]   pred_pc = '0;
  logic          pred_taken;
  logic [HL-1:0] pred_ghr;
  logic          upd_valid = 1'b0;
  logic [31:0]   upd_pc = '0;
  logic [HL-1:0] upd_ghr = '0;
  logic          upd_taken = 1'b0;
  logic          upd_mispredict = 1'b0;

  gshare_predictor #(
    .PHT_DEPTH(D),
    .CTR_WIDTH(W),
    .HIST_LEN (HL)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .pred_valid_i     (pred_valid),
    .pred_pc_i        (pred_pc),
    .pred_taken_o     (pred_taken),
    .pred_ghr_o       (pred_ghr),
    .upd_valid_i      (upd_valid),
    .upd_pc_i         (upd_pc),
    .upd_ghr_i        (upd_ghr),
    .upd_taken_i      (upd_taken),
    .upd_mispredict_i (upd_mispredict)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          pt;
    logic [HL-1:0] g;
    int            id;
  } exp_t;

  exp_t q[$];
  int   ctr[D];
  int   ghr;
  int   vecs = 0;
  int   errs = 0;
  int   seq  = 0;

  function automatic int pidx(input logic [31:0] pc, input int g);
    int b;
    b = int'(pc[7:2]);
`ifdef GSHARE_HISTORY_EN
    return b ^ g;
`else
    return b + 0 * g;
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < D; i++) ctr[i] = WT;
    ghr = 0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst            = 1'b1;
    pred_valid     = 1'($urandom);
    pred_pc        = $urandom;
    upd_valid      = 1'($urandom);
    upd_pc         = $urandom;
    upd_ghr        = HL'($urandom);
    upd_taken      = 1'($urandom);
    upd_mispredict = 1'($urandom);
    model_reset();
  endtask

  task automatic step(input logic pv, input logic [31:0] ppc,
                      input logic uv, input logic [31:0] upc,
                      input logic [HL-1:0] ughr, input logic ut,
                      input logic um, input int fpt);
    exp_t e;
    int   k;
    logic mpt;
    @(posedge clk); #1;
    rst            = 1'b0;
    pred_valid     = pv;
    pred_pc        = ppc;
    upd_valid      = uv;
    upd_pc         = upd_pc_sel(upc);
    upd_ghr        = ughr;
    upd_taken      = ut;
    upd_mispredict = um;
    mpt  = (ctr[pidx(ppc, ghr)] >= WT);
    e.pt = (fpt >= 0) ? (fpt != 0) : mpt;
    e.g  = HL'(ghr);
    e.id = seq++;
    q.push_back(e);
    if (uv) begin
      k = pidx(upc, int'(ughr));
      if (ut) ctr[k] = (ctr[k] == CMAX) ? CMAX : ctr[k] + 1;
      else    ctr[k] = (ctr[k] == 0) ? 0 : ctr[k] - 1;
    end
`ifdef GSHARE_HISTORY_EN
    if (uv && um) ghr = ((int'(ughr) * 2) + int'(ut)) % (1 << HL);
    else if (pv)  ghr = ((ghr * 2) + int'(mpt)) % (1 << HL);
`endif
  endtask

  function automatic logic [31:0] upd_pc_sel(input logic [31:0] p);
    return p;
  endfunction

  function automatic logic [31:0] rpc();
    logic [31:0] r;
    r = $urandom;
    if ($urandom_range(0, 1) == 0) r[7:2] = 6'($urandom_range(0, 7));
    return r;
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        e = q.pop_front();
        vecs++;
        if (pred_taken !== e.pt) begin
          errs++;
          $display("FAIL pred_taken #%0d: got %b expected %b",
                   e.id, pred_taken, e.pt);
        end
        vecs++;
        if (pred_ghr !== e.g) begin
          errs++;
          $display("FAIL pred_ghr #%0d: got %b expected %b",
                   e.id, pred_ghr, e.g);
        end
      end
    end
  end

  initial begin : stim
    int n;
    model_reset();
    repeat (2) do_reset();

    // Reset state: any PC predicts taken with empty history.
    step(1'b1, 32'h1234_5678, 1'b0, 32'h0, '0, 1'b0, 1'b0, 1);

    // Saturate to zero from weakly taken.
    do_reset();
    step(1'b0, 32'h100, 1'b1, 32'h100, '0, 1'b0, 1'b0, 1);
    step(1'b0, 32'h100, 1'b1, 32'h100, '0, 1'b0, 1'b0, -1);
    step(1'b0, 32'h100, 1'b1, 32'h100, '0, 1'b0, 1'b0, 0);
    step(1'b1, 32'h100, 1'b0, 32'h0, '0, 1'b0, 1'b0, 0);

    // Same-index predict and update: no bypass.
    do_reset();
    step(1'b0, 32'h40, 1'b1, 32'h40, '0, 1'b0, 1'b0, 1);
    step(1'b0, 32'h40, 1'b0, 32'h0, '0, 1'b0, 1'b0, 0);

    // Saturate high, then reset mid-training.
    do_reset();
    step(1'b0, 32'h80, 1'b1, 32'h80, '0, 1'b1, 1'b0, 1);
    step(1'b0, 32'h80, 1'b1, 32'h80, '0, 1'b1, 1'b0, 1);
    step(1'b1, 32'h80, 1'b1, 32'h80, '0, 1'b1, 1'b0, 1);
    do_reset();
    step(1'b0, 32'h80, 1'b1, 32'h80, '0, 1'b0, 1'b0, 1);
    step(1'b0, 32'h80, 1'b0, 32'h0, '0, 1'b0, 1'b0, 0);

`ifdef GSHARE_HISTORY_EN
    // History shifting with predictions 1,1,0.
    do_reset();
    step(1'b0, 32'h200, 1'b1, 32'h200, 6'd3, 1'b0, 1'b0, -1);
    step(1'b0, 32'h200, 1'b1, 32'h200, 6'd3, 1'b0, 1'b0, -1);
    step(1'b1, 32'h200, 1'b0, 32'h0, '0, 1'b0, 1'b0, 1);
    step(1'b1, 32'h200, 1'b0, 32'h0, '0, 1'b0, 1'b0, 1);
    step(1'b1, 32'h200, 1'b0, 32'h0, '0, 1'b0, 1'b0, 0);
    step(1'b0, 32'h200, 1'b0, 32'h0, '0, 1'b0, 1'b0, -1);

    // Mispredict repair beats the fetch shift.
    step(1'b1, 32'h300, 1'b1, 32'h404, 6'd5, 1'b1, 1'b1, -1);
    step(1'b0, 32'h300, 1'b0, 32'h0, '0, 1'b0, 1'b0, -1);
`endif

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 79) == 0) do_reset();
      n = $urandom_range(0, 3);
      step(1'($urandom_range(0, 3) != 0), rpc(),
           1'($urandom_range(0, 2) != 0), rpc(),
           HL'($urandom), 1'($urandom),
           1'(n == 0), -1);
    end

    for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
    @(posedge clk);
    if (q.size() != 0) begin
      vecs++;
      errs++;
      $display("FAIL drain: %0d left expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
